branch_predict_fetch: RTL and testbench

Parametrised instruction-fetch front end for the pipelined MIPS core. It replaces the fixed "PC+4, fix up in EX" program counter with a direct-mapped branch target buffer (BTB) of saturating counters. It predicts the next fetch address every cycle, resolves predictions against the EX stage outcome, and issues redirect/flush on a mispredict. It sits between the datapath's IF/ID pipeline register and the instruction cache port, and keeps branch and mispredict performance counters.

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/branch_target_buffer.sv | 79 +++++++
 rtl/branch_predict_fetch.sv | 92 +++++++++
 tb/tb_branch_predict_fetch.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus helpers for the fetch-stage branch target buffer.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef struct packed {
      word_t index;
      word_t tag;
   } btb_key_t;

   // Weakly-taken counter value: only the MSB set.
   function automatic int unsigned ctr_weak_taken(input int unsigned ctr_w);
      return 32'd1 << (ctr_w - 1);
   endfunction

   // Word-aligned PC split into a direct-mapped index and the remaining tag bits.
   function automatic btb_key_t btb_key(input word_t pc, input int unsigned idx_w);
      btb_key_t key;
      key.index = (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
      key.tag   = pc >> (idx_w + 2);
      return key;
   endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup port, clocked update port with
// saturating prediction counters.
module branch_target_buffer
   import cpu_types_pkg::*;
#(
   parameter int BTB_ENTRIES = 16,
   parameter int CTR_W       = 2
) (
   input  logic  CLK,
   input  logic  nRST,
   input  word_t lookup_pc,
   output logic  pred_taken,
   output word_t pred_target,
   input  logic  update_en,
   input  word_t update_pc,
   input  logic  update_taken,
   input  logic  update_jump,
   input  word_t update_target
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 32 - IDX_W - 2;

   typedef logic [CTR_W-1:0] ctr_t;
   localparam ctr_t CTR_ONE  = ctr_t'(1);
   localparam ctr_t CTR_MAX  = '1;
   localparam ctr_t CTR_WEAK = ctr_t'(ctr_weak_taken(CTR_W));

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      word_t            target;
      logic             is_jump;
      ctr_t             ctr;
   } entry_t;

   entry_t btb [BTB_ENTRIES];

   logic [IDX_W-1:0] lookup_idx, update_idx;
   logic [TAG_W-1:0] lookup_tag, update_tag;
   entry_t           lookup_entry, update_entry;
   logic             update_hit;

   always_comb begin
      lookup_idx   = IDX_W'(btb_key(lookup_pc, IDX_W).index);
      lookup_tag   = TAG_W'(btb_key(lookup_pc, IDX_W).tag);
      update_idx   = IDX_W'(btb_key(update_pc, IDX_W).index);
      update_tag   = TAG_W'(btb_key(update_pc, IDX_W).tag);
      lookup_entry = btb[lookup_idx];
      update_entry = btb[update_idx];
      update_hit   = update_entry.valid && (update_entry.tag == update_tag);
      pred_taken   = lookup_entry.valid && (lookup_entry.tag == lookup_tag)
                     && (lookup_entry.is_jump || lookup_entry.ctr[CTR_W-1]);
      pred_target  = lookup_entry.target;
   end

   // NOTE: the array is reset, not just the valid bits, so pred_target reads zero out of reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < BTB_ENTRIES; i++) btb[i] <= '0;
      end else if (update_en) begin
         if (update_hit) begin
            if (update_taken) begin
               btb[update_idx].target <= update_target;
               if (update_entry.ctr != CTR_MAX) btb[update_idx].ctr <= update_entry.ctr + CTR_ONE;
            end else if (update_entry.ctr != '0) begin
               btb[update_idx].ctr <= update_entry.ctr - CTR_ONE;
            end
         end else if (update_taken) begin
            btb[update_idx] <= '{valid:   1'b1,
                                 tag:     update_tag,
                                 target:  update_target,
                                 is_jump: update_jump,
                                 ctr:     update_jump ? CTR_MAX : CTR_WEAK};
         end
      end
   end

endmodule

// File: rtl/branch_predict_fetch.sv
// Fetch front end: PC register, BTB-predicted next PC, EX-stage mispredict
// redirect/flush, and saturating branch/mispredict counters.
module branch_predict_fetch
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT     = 32'h0,
   parameter int    BTB_ENTRIES = 16,
   parameter int    CTR_W       = 2,
   parameter int    CNT_W       = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             stall,
   input  logic             halt,
   input  logic             ex_valid,
   input  logic             ex_branch,
   input  logic             ex_jump,
   input  logic             ex_jr,
   input  logic             ex_taken,
   input  word_t            ex_pc,
   input  word_t            ex_target,
   input  logic             ex_pred_taken,
   input  word_t            ex_pred_target,
   output word_t            imemaddr,
   output logic             imemREN,
   output word_t            pc4,
   output logic             pred_taken,
   output word_t            pred_target,
   output logic             flush,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   word_t pc, next_pc, actual_next;
   logic  actual_taken, mispredict;

   assign imemaddr = pc;
   assign pc4      = pc + 32'd4;
   assign imemREN  = ~halt;
   assign flush    = mispredict & ~halt;

   always_comb begin
      actual_taken = ex_jump | ex_jr | (ex_branch & ex_taken);
      actual_next  = actual_taken ? ex_target : ex_pc + 32'd4;
      mispredict   = ex_valid & ((ex_pred_taken != actual_taken)
                                 | (actual_taken & (ex_pred_target != ex_target)));
   end

   // NOTE: next_pc gets its hold value first so no path through the priority chain infers a latch.
   always_comb begin
      next_pc = pc;
      if (halt)            next_pc = pc;
      else if (mispredict) next_pc = actual_next;
      else if (stall)      next_pc = pc;
      else if (ihit)       next_pc = pred_taken ? pred_target : pc4;
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pc          <= PC_INIT;
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         pc <= next_pc;
         if (!halt) begin
            if (ex_valid && branch_cnt != '1)   branch_cnt  <= branch_cnt + CNT_ONE;
            if (mispredict && mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_ONE;
         end
      end
   end

   branch_target_buffer #(
      .BTB_ENTRIES (BTB_ENTRIES),
      .CTR_W       (CTR_W)
   ) u_btb (
      .CLK           (CLK),
      .nRST          (nRST),
      .lookup_pc     (pc),
      .pred_taken    (pred_taken),
      .pred_target   (pred_target),
      .update_en     (ex_valid & ~halt & (ex_branch | ex_jump)),
      .update_pc     (ex_pc),
      .update_taken  (actual_taken),
      .update_jump   (ex_jump),
      .update_target (ex_target)
   );

endmodule

// File: tb/tb_branch_predict_fetch.sv
// Directed bench for branch_predict_fetch; a second instance with 2-bit
// performance counters shares the stimulus to show counter saturation.
module tb_branch_predict_fetch;
   import cpu_types_pkg::*;

   logic  CLK, nRST, ihit, stall, halt;
   logic  ex_valid, ex_branch, ex_jump, ex_jr, ex_taken, ex_pred_taken;
   word_t ex_pc, ex_target, ex_pred_target;

   word_t       imemaddr, pc4, pred_target;
   logic        imemREN, pred_taken, flush;
   logic [31:0] branch_cnt, mispred_cnt;

   word_t       s_imemaddr, s_pc4, s_pred_target;
   logic        s_imemREN, s_pred_taken, s_flush;
   logic [1:0]  s_branch_cnt, s_mispred_cnt;

   int checks = 0;
   int errors = 0;
   int exp_br = 0;
   int exp_mp = 0;

   branch_predict_fetch #(.PC_INIT(32'h0), .BTB_ENTRIES(16), .CTR_W(2), .CNT_W(32)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .halt(halt),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jr(ex_jr),
      .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .imemaddr(imemaddr), .imemREN(imemREN), .pc4(pc4), .pred_taken(pred_taken),
      .pred_target(pred_target), .flush(flush), .branch_cnt(branch_cnt),
      .mispred_cnt(mispred_cnt)
   );

   branch_predict_fetch #(.PC_INIT(32'h0), .BTB_ENTRIES(16), .CTR_W(2), .CNT_W(2)) dut_small (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .halt(halt),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jr(ex_jr),
      .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .imemaddr(s_imemaddr), .imemREN(s_imemREN), .pc4(s_pc4), .pred_taken(s_pred_taken),
      .pred_target(s_pred_target), .flush(s_flush), .branch_cnt(s_branch_cnt),
      .mispred_cnt(s_mispred_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_ex(input logic br, input logic j, input logic jr, input logic tk,
                         input word_t pc, input word_t tgt, input logic pt, input word_t ptgt);
      ex_valid = 1'b1; ex_branch = br; ex_jump = j; ex_jr = jr; ex_taken = tk;
      ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
   endtask

   task automatic clr_ex();
      ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0; ex_jr = 1'b0; ex_taken = 1'b0;
      ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
   endtask

   // Steer the PC with a never-allocated JR predicted not-taken (always a mispredict).
   task automatic redirect(input word_t tgt);
      set_ex(1'b0, 1'b0, 1'b1, 1'b0, 32'h200, tgt, 1'b0, 32'h0);
      tick();
      clr_ex();
      exp_br++;
      exp_mp++;
      #1;
   endtask

   initial begin
      nRST = 1'b0; ihit = 1'b0; stall = 1'b0; halt = 1'b0;
      clr_ex();

      #12;
      check("reset_imemaddr", imemaddr, 32'h0);
      check("reset_pred_taken", 32'(pred_taken), 32'h0);
      check("reset_pred_target", pred_target, 32'h0);
      check("reset_flush", 32'(flush), 32'h0);
      check("reset_imemREN", 32'(imemREN), 32'h1);
      check("reset_branch_cnt", branch_cnt, 32'h0);
      check("reset_mispred_cnt", mispred_cnt, 32'h0);

      nRST = 1'b1;
      ihit = 1'b1;
      tick();
      check("seq_pc_4", imemaddr, 32'h4);
      check("seq_pred_taken", 32'(pred_taken), 32'h0);
      tick();
      check("seq_pc_8", imemaddr, 32'h8);
      check("seq_pc4", pc4, 32'hC);

      #3 nRST = 1'b0;
      #1 check("async_reset_pc", imemaddr, 32'h0);
      ihit = 1'b0;
      #2 nRST = 1'b1;
      tick();
      check("hold_no_ihit", imemaddr, 32'h0);

      // Cold taken BEQ at 0x10 -> 0x40.
      set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h40, 1'b0, 32'h0);
      #1 check("cold_beq_flush", 32'(flush), 32'h1);
      tick();
      clr_ex();
      exp_br++; exp_mp++;
      check("cold_beq_pc", imemaddr, 32'h40);
      check("cold_beq_branch_cnt", branch_cnt, 32'(exp_br));
      check("cold_beq_mispred_cnt", mispred_cnt, 32'(exp_mp));
      check("small_mispred_cnt_1", 32'(s_mispred_cnt), 32'h1);
      #1 check("flush_cleared", 32'(flush), 32'h0);

      redirect(32'h10);
      check("redirect_pc_10", imemaddr, 32'h10);
      check("alloc_pred_taken", 32'(pred_taken), 32'h1);
      check("alloc_pred_target", pred_target, 32'h40);

      // Not-taken training 2 -> 1 -> 0 -> 0; lookup sees pre-update contents.
      set_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h40, 1'b0, 32'h0);
      #1 check("pre_update_pred_taken", 32'(pred_taken), 32'h1);
      check("nt_correct_no_flush", 32'(flush), 32'h0);
      tick(); exp_br++;
      check("train_ctr1_pred", 32'(pred_taken), 32'h0);
      tick(); exp_br++;
      check("train_ctr0_pred", 32'(pred_taken), 32'h0);
      tick(); exp_br++;
      check("train_sat0_pred", 32'(pred_taken), 32'h0);

      // Two correctly-predicted taken resolutions: 0 -> 1 -> 2.
      set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h40, 1'b1, 32'h40);
      #1 check("taken_correct_no_flush", 32'(flush), 32'h0);
      tick(); exp_br++;
      check("retrain_ctr1_pred", 32'(pred_taken), 32'h0);
      tick(); exp_br++;
      clr_ex();
      #1;
      check("retrain_ctr2_pred", 32'(pred_taken), 32'h1);
      check("train_pc_held", imemaddr, 32'h10);
      check("train_branch_cnt", branch_cnt, 32'(exp_br));
      check("train_mispred_cnt", mispred_cnt, 32'(exp_mp));

      // Stall holds even with a taken prediction available; mispredict beats stall.
      ihit = 1'b1; stall = 1'b1;
      tick();
      check("stall_hold", imemaddr, 32'h10);
      set_ex(1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h80, 1'b0, 32'h0);
      #1 check("stall_mispredict_flush", 32'(flush), 32'h1);
      tick(); exp_br++; exp_mp++;
      clr_ex();
      check("stall_mispredict_pc", imemaddr, 32'h80);
      stall = 1'b0;
      tick();
      check("ihit_pc4", imemaddr, 32'h84);

      // Halt during a mispredict: nothing changes, no flush.
      halt = 1'b1;
      set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h84, 32'h400, 1'b0, 32'h0);
      #1 check("halt_flush", 32'(flush), 32'h0);
      check("halt_imemREN", 32'(imemREN), 32'h0);
      tick();
      clr_ex();
      check("halt_pc", imemaddr, 32'h84);
      check("halt_branch_cnt", branch_cnt, 32'(exp_br));
      check("halt_mispred_cnt", mispred_cnt, 32'(exp_mp));
      halt = 1'b0; ihit = 1'b0;
      #1 check("halt_no_alloc", 32'(pred_taken), 32'h0);
      check("unhalt_imemREN", 32'(imemREN), 32'h1);

      // Aliasing: 0x50 shares index 4 with 0x10 and evicts it.
      set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h50, 32'h60, 1'b0, 32'h0);
      tick(); exp_br++; exp_mp++;
      clr_ex();
      check("alias_pc", imemaddr, 32'h60);
      redirect(32'h10);
      check("alias_evicted_pred", 32'(pred_taken), 32'h0);
      redirect(32'h50);
      check("alias_new_pred", 32'(pred_taken), 32'h1);
      check("alias_new_target", pred_target, 32'h60);

      // JR is redirected but never allocated.
      set_ex(1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h100, 1'b0, 32'h0);
      #1 check("jr_flush", 32'(flush), 32'h1);
      tick(); exp_br++; exp_mp++;
      clr_ex();
      check("jr_pc", imemaddr, 32'h100);
      redirect(32'h20);
      check("jr_no_alloc", 32'(pred_taken), 32'h0);

      check("final_branch_cnt", branch_cnt, 32'(exp_br));
      check("final_mispred_cnt", mispred_cnt, 32'(exp_mp));
      check("small_mispred_sat", 32'(s_mispred_cnt), 32'h3);
      check("small_branch_sat", 32'(s_branch_cnt), 32'h3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
